// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - CPU-to-memory req/ack bus controller with core stall and timeout error
module cpu_bus_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_rdwr,
    input  logic                  cpu_which_rdwr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data_out,
    output logic [DATA_WIDTH-1:0] cpu_data_in,
    output logic                  cpu_enable,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  err_clr,
    output logic                  bus_error,
    output logic                  busy
);

    // Encoding of cpu_which_rdwr for a read access
    localparam logic WHICH_READ = 1'b0;

    // Counter only needs to reach TIMEOUT_CYCLES-1; it is cleared on every REQ entry
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic              start_access;
    logic              ack_done;
    logic              timeout_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the single-cycle events that drive the datapath
    always_comb begin
        state_next   = state;
        start_access = 1'b0;
        ack_done     = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req_rdwr) begin
                    start_access = 1'b1;
                    state_next   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    ack_done   = 1'b1;
                    state_next = ST_DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Core stall: frozen as soon as a request is seen, released only for the DONE cycle
    always_comb begin
        cpu_enable = ((state == ST_IDLE) && !cpu_req_rdwr) || (state == ST_DONE);
    end

    // Memory-side registers, read data return, wait counter, error flag and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cpu_data_in <= '0;
            wait_cnt    <= '0;
            bus_error   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (start_access) begin
                mem_req     <= 1'b1;
                mem_we      <= cpu_which_rdwr;
                mem_addr    <= cpu_addr;
                mem_wr_data <= cpu_data_out;
                wait_cnt    <= '0;
            end else if (ack_done) begin
                mem_req <= 1'b0;
                if (mem_we == WHICH_READ) begin
                    cpu_data_in <= mem_rd_data;
                end
            end else if (timeout_hit) begin
                mem_req <= 1'b0;
                if (mem_we == WHICH_READ) begin
                    cpu_data_in <= '1;
                end
            end else if (state == ST_REQ) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // A timeout in the same cycle as err_clr keeps the error set
            if (timeout_hit) begin
                bus_error <= 1'b1;
            end else if (err_clr) begin
                bus_error <= 1'b0;
            end

            busy <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - table-driven scoreboard bench for cpu_bus_ctrl
module tb_cpu_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_rdwr;
    logic        cpu_which_rdwr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;
    logic        cpu_enable;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_ack;
    logic [7:0]  mem_rd_data;
    logic        err_clr;
    logic        bus_error;
    logic        busy;

    always #5 clk = ~clk;

    cpu_bus_ctrl #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_rdwr  (cpu_req_rdwr),
        .cpu_which_rdwr(cpu_which_rdwr),
        .cpu_addr      (cpu_addr),
        .cpu_data_out  (cpu_data_out),
        .cpu_data_in   (cpu_data_in),
        .cpu_enable    (cpu_enable),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_ack       (mem_ack),
        .mem_rd_data   (mem_rd_data),
        .err_clr       (err_clr),
        .bus_error     (bus_error),
        .busy          (busy)
    );

    // ack_cyc = 0 means memory never acks; exp_done is the cycle number of DONE
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          ack_cyc;
        bit          clr_pre;
        bit          clr_last;
        logic [7:0]  exp_data;
        bit          exp_err;
        int          exp_done;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         done;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v, input int idx);
        exp_t e;
        int   cyc;
        bit   done;
        @(negedge clk);
        if (v.clr_pre) begin
            err_clr     = 1'b1;
            mem_ack     = 1'b1;
            mem_rd_data = 8'h11;
            @(negedge clk);
            err_clr = 1'b0;
            mem_ack = 1'b0;
            #1;
            chk($sformatf("v%0d err_clr clears", idx), bus_error, 0);
            chk($sformatf("v%0d stray ack data", idx), cpu_data_in, model_data);
            chk($sformatf("v%0d stray ack busy", idx), busy, 0);
        end
        cpu_req_rdwr   = 1'b1;
        cpu_which_rdwr = v.we;
        cpu_addr       = v.addr;
        cpu_data_out   = v.wdata;
        #1;
        chk($sformatf("v%0d enable c0", idx), cpu_enable, 0);
        e.data = v.exp_data;
        e.err  = v.exp_err;
        e.done = v.exp_done;
        sb.push_back(e);
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            err_clr = 1'b0;
            #1;
            if (cpu_enable && busy) begin
                done = 1'b1;
                e    = sb.pop_front();
                chk($sformatf("v%0d done cycle", idx), cyc, e.done);
                chk($sformatf("v%0d data_in", idx), cpu_data_in, e.data);
                chk($sformatf("v%0d bus_error", idx), bus_error, e.err);
                chk($sformatf("v%0d mem_req done", idx), mem_req, 0);
                cpu_req_rdwr = 1'b0;
                model_data   = e.data;
            end else if (cyc > 40) begin
                done = 1'b1;
                checks++;
                errors++;
                $display("FAIL v%0d no DONE within 40 cycles", idx);
                e            = sb.pop_front();
                cpu_req_rdwr = 1'b0;
            end else begin
                chk($sformatf("v%0d mem_req c%0d", idx, cyc), mem_req, 1);
                chk($sformatf("v%0d mem_we c%0d", idx, cyc), mem_we, v.we);
                chk($sformatf("v%0d mem_addr c%0d", idx, cyc), mem_addr, v.addr);
                chk($sformatf("v%0d mem_wr_data c%0d", idx, cyc), mem_wr_data, v.wdata);
                chk($sformatf("v%0d enable c%0d", idx, cyc), cpu_enable, 0);
                if (cyc == v.ack_cyc) begin
                    mem_ack     = 1'b1;
                    mem_rd_data = v.rdata;
                end
                if (v.clr_last && cyc == 16) begin
                    err_clr = 1'b1;
                end
            end
        end
    endtask

    initial begin
        vec_t v;
        //         we    addr      wdata  rdata  ack clrp clrl exp_d  err done
        vecs[0] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 1,  0,   0,   8'hA5, 0,  2};
        vecs[1] = '{1'b1, 16'hFFFF, 8'h5A, 8'hEE, 4,  0,   0,   8'hA5, 0,  5};
        vecs[2] = '{1'b0, 16'h0001, 8'h00, 8'h3C, 2,  0,   0,   8'h3C, 0,  3};
        vecs[3] = '{1'b0, 16'h4321, 8'h00, 8'h99, 0,  0,   0,   8'hFF, 1,  17};
        vecs[4] = '{1'b0, 16'hABCD, 8'h00, 8'h77, 16, 1,   0,   8'h77, 0,  17};
        vecs[5] = '{1'b1, 16'h0000, 8'hA3, 8'h12, 1,  0,   0,   8'h77, 0,  2};
        vecs[6] = '{1'b0, 16'h8000, 8'h00, 8'h00, 0,  0,   1,   8'hFF, 1,  17};
        vecs[7] = '{1'b0, 16'h00FF, 8'h00, 8'hC3, 1,  1,   0,   8'hC3, 0,  2};

        rst            = 1'b1;
        cpu_req_rdwr   = 1'b0;
        cpu_which_rdwr = 1'b0;
        cpu_addr       = '0;
        cpu_data_out   = '0;
        mem_ack        = 1'b0;
        mem_rd_data    = '0;
        err_clr        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wr_data", mem_wr_data, 0);
        chk("rst cpu_data_in", cpu_data_in, 0);
        chk("rst bus_error", bus_error, 0);
        chk("rst busy", busy, 0);
        chk("rst cpu_enable", cpu_enable, 1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i], i);
        end

        // Reset in cycle 2 of a pending read, then a late ack
        @(negedge clk);
        cpu_req_rdwr   = 1'b1;
        cpu_which_rdwr = 1'b0;
        cpu_addr       = 16'h2222;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        cpu_req_rdwr = 1'b0;
        mem_ack      = 1'b1;
        mem_rd_data  = 8'h55;
        #1;
        chk("midrst mem_req", mem_req, 0);
        chk("midrst busy", busy, 0);
        chk("midrst cpu_data_in", cpu_data_in, 0);
        chk("midrst cpu_enable", cpu_enable, 1);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late ack data", cpu_data_in, 0);
        chk("late ack busy", busy, 0);
        model_data = 8'h00;
        v = '{1'b0, 16'h3333, 8'h00, 8'h4E, 1, 0, 0, 8'h4E, 0, 2};
        run_access(v, 8);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Bus controller directly downstream of the `Cpu` core. It accepts the core's `req_rdwr`/`which_rdwr`/`addr`/`data_out` request, runs a req/ack handshake with the memory system, returns read data on the core's `data_in`, and stalls the core through its `enable` input while an access is outstanding. A bounded wait counter turns a missing ack into a sticky bus error, so a dead slave cannot hang the core.

## Interface
- `ADDR_WIDTH`, 16, width of the CPU absolute address and `mem_addr`.
- `DATA_WIDTH`, 8, data byte width.
- `TIMEOUT_CYCLES`, 16, maximum number of REQ cycles before abort; legal range is 2..256.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_req_rdwr`  in  1  core requests an access; held until the core is re-enabled.
- `cpu_which_rdwr`  in  1  0 = read (`ENUM__CPU_WHICH_RDWR__READ`), 1 = write (`ENUM__CPU_WHICH_RDWR__WRITE`).
- `cpu_addr`  in  ADDR_WIDTH  access address.
- `cpu_data_out`  in  DATA_WIDTH  write data from the core.
- `cpu_data_in`  out  DATA_WIDTH  registered read data to the core.
- `cpu_enable`  out  1  drives the core `enable`; combinational from state and `cpu_req_rdwr`.
- `mem_req`  out  1  registered access request to memory.
- `mem_we`  out  1  registered; 1 = write.
- `mem_addr`  out  ADDR_WIDTH  registered address.
- `mem_wr_data`  out  DATA_WIDTH  registered write data.
- `mem_ack`  in  1  memory completes the access; read data is valid in the same cycle.
- `mem_rd_data`  in  DATA_WIDTH  read data, sampled only with `mem_ack`.
- `err_clr`  in  1  clears `bus_error`.
- `bus_error`  out  1  sticky; an access timed out.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- Reset values: state IDLE; `mem_req`, `mem_we` and `bus_error` are 0; `mem_addr`, `mem_wr_data` and `cpu_data_in` are 0; wait counter 0.
- `cpu_enable` = (IDLE && !`cpu_req_rdwr`) || DONE. It is 0 in REQ.
  - Consequence: the core is frozen in the same cycle its request is first seen.
- IDLE with `cpu_req_rdwr`=1:
  - Latch `cpu_addr` into `mem_addr`, `cpu_which_rdwr` into `mem_we`, and `cpu_data_out` into `mem_wr_data`.
  - Set `mem_req`=1, clear the counter, go to REQ.
- REQ with `mem_ack`=1:
  - Clear `mem_req`.
  - Reads load `mem_rd_data` into `cpu_data_in`; writes leave `cpu_data_in` unchanged.
  - Go to DONE.
- REQ with `mem_ack`=0 and counter == TIMEOUT_CYCLES-1:
  - Clear `mem_req` and set `bus_error`.
  - Reads load all-ones (8'hFF) into `cpu_data_in`.
  - Go to DONE.
- REQ otherwise: increment the counter.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wr_data` stay stable for the whole REQ period.
- DONE: one cycle with `cpu_enable`=1, then go to IDLE unconditionally.
  - A request the core raises at this edge is picked up in IDLE.
- Counter width is clog2(TIMEOUT_CYCLES); it never wraps, because the counter is cleared on REQ entry.
- `mem_ack` outside REQ is ignored and has no state effect.
- `err_clr`:
  - Clears `bus_error` on the next edge.
  - A timeout in the same cycle wins, so `bus_error` ends at 1.
- `rst` mid-access: everything returns to reset values on that edge and `mem_req` drops. Memory must tolerate an abandoned request.

## Timing
- Cycle 0 is the IDLE cycle in which `cpu_req_rdwr` is seen.
- `mem_req` is high from cycle 1.
- With ack in cycle k (k≥1): DONE is cycle k+1, and `cpu_data_in` is valid from cycle k+1.
- The core's enabled edge is the end of cycle k+1.
- Zero-wait memory (ack in cycle 1): 3 cycles per access, and back-to-back accesses also run at 3 cycles each.
- Timeout: REQ lasts exactly TIMEOUT_CYCLES cycles (cycles 1..TIMEOUT_CYCLES); DONE is cycle TIMEOUT_CYCLES+1.
- Ack arriving in the final permitted REQ cycle is a normal completion: no error, and the real data is returned.
- `busy` is registered and equals state≠IDLE.

## Test plan
- Reset: apply `rst` for 2 cycles -> all outputs are 0, `cpu_enable`=1 with `cpu_req_rdwr`=0, and `busy`=0.
- Read, zero-wait: read at 16'h1234, memory acks in cycle 1 with 8'hA5 -> `mem_addr`=16'h1234 and `mem_we`=0 in cycle 1; `cpu_data_in`=8'hA5 and `cpu_enable`=1 in cycle 2; `cpu_enable`=0 in cycles 0–1.
- Write, 3 wait states: write 8'h5A to 16'hFFFF, ack in cycle 4 -> `mem_req`/`mem_we`/`mem_wr_data` are stable across cycles 1–4; DONE in cycle 5; `cpu_data_in` unchanged; no error.
- Timeout: with TIMEOUT_CYCLES=16, a read that is never acked -> `mem_req` falls after cycle 16, `bus_error`=1, `cpu_data_in`=8'hFF. A later ack is ignored. `err_clr` clears the error.
- Boundary: ack exactly in cycle 16 -> normal read data and `bus_error`=0. Separately, `err_clr` in the same cycle as a timeout -> `bus_error`=1.
- Reset mid-access: `rst` in cycle 2 of a pending read -> `mem_req`=0 and state IDLE on the next edge; a late ack causes no `cpu_data_in` change; the next request proceeds normally.
